// File: rtl/secded_stream_encoder.sv
// Two-stage valid/ready SECDED (39,32) encoder producing extended-Hamming codewords.
// Optional single-bit error injection is compiled in with `define ERR_INJECT_EN.
module secded_stream_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [38:0]      out_code,
   output logic [CNT_W-1:0] enc_count
`ifdef ERR_INJECT_EN
   ,
   input  logic             inj_en,
   input  logic [5:0]       inj_pos
`endif
);

   localparam int M = 32;
   localparam int P = 7;
   localparam int N = M + P;

   // Hamming positions 1..38 live at bit j-1; data takes every non-power-of-two position.
   function automatic logic [N-2:0] hamming_encode(input logic [M-1:0] d);
      logic [N-2:0] w;
      int           k;
      logic         p;
      w = '0;
      k = 0;
      for (int j = 1; j <= N - 1; j++) begin
         if ((j & (j - 32'sd1)) != 32'sd0) begin
            w[j-1] = d[k];
            k      = k + 1;
         end else begin
            w[j-1] = 1'b0;
         end
      end
      for (int i = 0; i < P - 1; i++) begin
         p = 1'b0;
         for (int j = 1; j <= N - 1; j++) begin
            if (((j & (j - 32'sd1)) != 32'sd0) && (((j >> i) & 32'sd1) != 32'sd0)) begin
               p = p ^ w[j-1];
            end else begin
               p = p;
            end
         end
         w[(32'sd1 << i) - 32'sd1] = p;
      end
      return w;
   endfunction

   function automatic logic overall_parity(input logic [N-2:0] w);
      return ^w;
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [N-2:0]     s1_word_q,  s1_word_d;
   logic             s2_valid_q, s2_valid_d;
   logic [N-1:0]     s2_code_q,  s2_code_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             s1_adv;
   logic             s2_adv;
   logic [N-1:0]     clean_code;
`ifdef ERR_INJECT_EN
   logic             s1_inj_en_q,  s1_inj_en_d;
   logic [5:0]       s1_inj_pos_q, s1_inj_pos_d;
   logic [N-1:0]     flip;
`endif

   // Handshake, pipeline advance and handoff counter next-state.
   always_comb begin
      s2_adv     = ~s2_valid_q | out_ready;
      s1_adv     = ~s1_valid_q | s2_adv;
      s1_valid_d = s1_valid_q;
      s1_word_d  = s1_word_q;
      s2_valid_d = s2_valid_q;
      s2_code_d  = s2_code_q;
      cnt_d      = cnt_q;
      clean_code = {overall_parity(s1_word_q), s1_word_q};
`ifdef ERR_INJECT_EN
      s1_inj_en_d  = s1_inj_en_q;
      s1_inj_pos_d = s1_inj_pos_q;
      flip         = '0;
      // The flip lands after overall parity, so it is a genuine single-bit error.
      if (s1_inj_en_q && (s1_inj_pos_q <= 6'd38)) begin
         flip[s1_inj_pos_q] = 1'b1;
      end else begin
         flip = '0;
      end
`endif
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_word_d = hamming_encode(in_data);
`ifdef ERR_INJECT_EN
            s1_inj_en_d  = inj_en;
            s1_inj_pos_d = inj_pos;
`endif
         end else begin
            s1_word_d = s1_word_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
`ifdef ERR_INJECT_EN
            s2_code_d = clean_code ^ flip;
`else
            s2_code_d = clean_code;
`endif
         end else begin
            s2_code_d = s2_code_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
      if (s2_valid_q && out_ready) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline and counter state; reset drops any in-flight words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_word_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_code_q  <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_word_q  <= s1_word_d;
         s2_valid_q <= s2_valid_d;
         s2_code_q  <= s2_code_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef ERR_INJECT_EN
   // Injection controls ride along with the word held in S1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_inj_en_q  <= 1'b0;
         s1_inj_pos_q <= 6'd0;
      end else begin
         s1_inj_en_q  <= s1_inj_en_d;
         s1_inj_pos_q <= s1_inj_pos_d;
      end
   end
`endif

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign out_code  = s2_code_q;
   assign enc_count = cnt_q;

endmodule

// File: tb/tb_secded_stream_encoder.sv
// Directed-vector and decoder-model bench for secded_stream_encoder.
// Define ERR_INJECT_EN for both files to exercise the injection path.
module tb_secded_stream_encoder;

   localparam int CNT_W = 16;
   localparam int NV    = 5;
   localparam int NR    = 10000;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [38:0]      out_code;
   logic [CNT_W-1:0] enc_count;
`ifdef ERR_INJECT_EN
   logic             inj_en;
   logic [5:0]       inj_pos;
`endif

   typedef struct {
      logic [31:0] data;
      logic [38:0] code;
   } vec_t;

   vec_t vecs [NV];
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt  = 0;

   secded_stream_encoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .enc_count (enc_count)
`ifdef ERR_INJECT_EN
      ,
      .inj_en    (inj_en),
      .inj_pos   (inj_pos)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Receiver-side model: syndrome is XOR of set positions, data from non-power-of-two positions.
   task automatic decode(input logic [38:0] c, output logic [5:0] syn, output logic ovr,
                         output logic [31:0] d);
      int k;
      k   = 0;
      syn = 6'd0;
      ovr = ^c;
      d   = 32'd0;
      for (int j = 1; j <= 38; j++) begin
         if (c[j-1]) syn = syn ^ 6'(j);
         if ((j & (j - 1)) != 0) begin
            d[k] = c[j-1];
            k++;
         end
      end
   endtask

   initial begin
      logic [5:0]  syn;
      logic        ovr;
      logic [31:0] dd;
      logic [31:0] q [$];
      logic [38:0] exp_codes [3];
      logic [38:0] prev_code;
      logic        stalled;
      int          sent, got, cyc, idx, stale;

      vecs[0] = '{32'h0000_0000, 39'h00_0000_0000};
      vecs[1] = '{32'h0000_0001, 39'h40_0000_0007};
      vecs[2] = '{32'h8000_0000, 39'h20_8000_000A};
      vecs[3] = '{32'h0000_0002, 39'h40_0000_0019};
      vecs[4] = '{32'hFFFF_FFFF, 39'h3F_7FFF_FFF4};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b0;
`ifdef ERR_INJECT_EN
      inj_en    = 1'b0;
      inj_pos   = 6'd0;
`endif
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_code", 64'(out_code), 64'd0);
      chk("rst_enc_count", 64'(enc_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Single word: latency and first handoff count.
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h0000_0000; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("lat_one_edge", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1 chk("lat_two_edges", 64'(out_valid), 64'd1);
      chk("first_code", 64'(out_code), 64'd0);
      @(negedge clk);
      #1 chk("first_count", 64'(enc_count), 64'd1);
      exp_cnt = 1;

      // Table vectors back to back at full throughput.
      for (int k = 0; k < NV + 2; k++) begin
         @(negedge clk);
         if (k < NV) begin
            in_valid = 1'b1; in_data = vecs[k].data;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (k < NV) chk($sformatf("b2b_ready_%0d", k), 64'(in_ready), 64'd1);
         if (k >= 2) begin
            chk($sformatf("vec_valid_%0d", k - 2), 64'(out_valid), 64'd1);
            chk($sformatf("vec_code_%0d", k - 2), 64'(out_code), 64'(vecs[k-2].code));
         end
      end
      exp_cnt += NV;
      @(negedge clk);
      #1 chk("table_count", 64'(enc_count), 64'(exp_cnt % 65536));

`ifdef ERR_INJECT_EN
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h0000_0001; inj_en = 1'b1; inj_pos = 6'd2;
      @(negedge clk);
      inj_pos = 6'd45;
      @(negedge clk);
      in_valid = 1'b0; inj_en = 1'b0;
      #1 chk("inj_code", 64'(out_code), 64'h40_0000_0003);
      decode(out_code, syn, ovr, dd);
      chk("inj_synd", 64'({ovr, syn}), 64'({1'b1, 6'd3}));
      @(negedge clk);
      #1 chk("inj_out_of_range", 64'(out_code), 64'h40_0000_0007);
      exp_cnt += 2;
`endif

      // Stall: two words fill the pipe, the third is refused until release.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[1].data;
      #1 chk("stall_acc1", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_data = vecs[2].data;
      #1 chk("stall_acc2", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_data = vecs[4].data;
      #1 chk("stall_full", 64'(in_ready), 64'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = c[0]; in_data = $urandom;
         #1;
         chk("stall_ready_low", 64'(in_ready), 64'd0);
         chk("stall_hold", 64'({out_valid, out_code}), 64'({1'b1, vecs[1].code}));
      end
      exp_codes[0] = vecs[1].code;
      exp_codes[1] = vecs[2].code;
      exp_codes[2] = vecs[4].code;
      idx = 0;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_data = vecs[4].data;
      #1 chk("release_accept", 64'(in_ready), 64'd1);
      for (int c = 0; c < 10 && idx < 3; c++) begin
         if (out_valid && out_ready) begin
            chk($sformatf("drain_%0d", idx), 64'(out_code), 64'(exp_codes[idx]));
            idx++;
         end
         @(negedge clk);
         in_valid = 1'b0;
         #1;
      end
      chk("drain_total", 64'(idx), 64'd3);
      exp_cnt += 3;

      // Asynchronous reset with both stages full.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[3].data;
      @(negedge clk);
      in_data = vecs[4].data;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_count", 64'(enc_count), 64'd0);
      chk("mid_rst_code", 64'(out_code), 64'd0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1 chk("post_rst_ready", 64'(in_ready), 64'd1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1 if (out_valid) stale++;
      end
      chk("no_stale_word", 64'(stale), 64'd0);
      exp_cnt = 0;

      // Random stream with random backpressure, checked through the decoder model.
      sent = 0; got = 0; cyc = 0; stalled = 1'b0; prev_code = 39'd0;
      while (got < NR && cyc < 60000) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 3) != 0);
         if (sent < NR) begin
            in_valid = $urandom_range(0, 1) != 0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stalled) chk("rand_stall_hold", 64'({out_valid, out_code}), 64'({1'b1, prev_code}));
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rand_spurious", 64'd1, 64'd0);
            end else begin
               decode(out_code, syn, ovr, dd);
               chk("rand_synd", 64'({ovr, syn}), 64'd0);
               chk("rand_data", 64'(dd), 64'(q.pop_front()));
            end
            got++;
         end
         stalled   = out_valid && !out_ready;
         prev_code = out_code;
         cyc++;
      end
      chk("rand_received", 64'(got), 64'(NR));
      chk("rand_leftover", 64'(q.size()), 64'd0);
      exp_cnt += NR;
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("rand_count", 64'(enc_count), 64'(exp_cnt % 65536));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
